// File: rtl/cache_refill_ctrl_pkg.sv
// Shared types and constants for the cache refill engine.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package cache_refill_ctrl_pkg;

    localparam int WORDS_LOG2_DEF = 10;
    localparam int BLOCK_WORDS    = 1 << WORDS_LOG2_DEF;

    // Requester identifiers; the grant register holds one of these.
    localparam logic SEL_I = 1'b0;
    localparam logic SEL_D = 1'b1;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        GRANT    = 3'd1,
        RD_REQ   = 3'd2,
        WR_CACHE = 3'd3,
        DONE     = 3'd4,
        WB_RD    = 3'd5,
        WB_REQ   = 3'd6
    } state_t;

endpackage

// File: rtl/cache_refill_ctrl_rr_arb2.sv
// Two-requester round-robin arbiter with a registered grant.
// Latency: grant registered on the edge where load is high and a request is present.
// Backpressure: none; requests are levels, the owner releases via update.
//
// Ports: req_i/req_d requests, load = sample point, update = commit grant as last
// winner, gnt = registered winner (SEL_I / SEL_D).
module rr_arb2
    import cache_refill_ctrl_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic req_i,
    input  logic req_d,
    input  logic load,
    input  logic update,
    output logic gnt
);

    logic last_grant;
    logic winner;

    // On a tie the requester that did not win last time goes first.
    always_comb begin
        winner = SEL_I;
        if (req_i && req_d) begin
            winner = ~last_grant;
        end else if (req_d) begin
            winner = SEL_D;
        end
    end

    // last_grant resets to D so that I wins the first tie.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gnt        <= SEL_I;
            last_grant <= SEL_D;
        end else begin
            if (load && (req_i || req_d)) begin
                gnt <= winner;
            end
            if (update) begin
                last_grant <= gnt;
            end
        end
    end

endmodule

// File: rtl/cache_refill_ctrl.sv
// Refill engine: copies a block from external memory into the granted I/D bank port B.
// Latency: 2 cycles/word zero-wait; 2*2^WORDS_LOG2+2 cycles from request sample to Done.
// Backpressure: EXT_Req/EXT_Addr held until EXT_Ack; new requests wait in IDLE.
//
// Ports: I_*/D_* bank port B (Addr, Din, WE) plus change_req/Base_Addr/Done handshake;
// D_Dout/D_Dirty/D_Old_Base feed the optional writeback; EXT_* is the external
// memory request/ack interface (EXT_Din valid in the EXT_Ack cycle).
// Build option: define REFILL_WRITEBACK_EN to write a dirty D block back before refill.
module cache_refill_ctrl
    import cache_refill_ctrl_pkg::*;
#(
    parameter int WORDS_LOG2 = WORDS_LOG2_DEF,
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              I_change_req,
    input  logic [ADDR_W-1:0] I_Base_Addr,
    output logic [ADDR_W-1:0] I_Addr,
    output logic [DATA_W-1:0] I_Din,
    output logic              I_WE,
    output logic              I_Done,
    input  logic              D_change_req,
    input  logic [ADDR_W-1:0] D_Base_Addr,
    output logic [ADDR_W-1:0] D_Addr,
    output logic [DATA_W-1:0] D_Din,
    output logic              D_WE,
    output logic              D_Done,
    input  logic [DATA_W-1:0] D_Dout,
    input  logic              D_Dirty,
    input  logic [ADDR_W-1:0] D_Old_Base,
    output logic              EXT_Req,
    output logic              EXT_WE,
    output logic [ADDR_W-1:0] EXT_Addr,
    output logic [DATA_W-1:0] EXT_Dout,
    input  logic [DATA_W-1:0] EXT_Din,
    input  logic              EXT_Ack
);

    localparam int TAG_W = ADDR_W - WORDS_LOG2;
    localparam logic [WORDS_LOG2-1:0] CNT_LAST = '1;

    state_t                state;
    logic [WORDS_LOG2-1:0] cnt;
    logic [WORDS_LOG2-1:0] cnt_nxt;
    logic [TAG_W-1:0]      base_r;
    logic [TAG_W-1:0]      sel_tag;
    logic [ADDR_W-1:0]     bank_addr;
    logic                  sel;
    logic                  unused_bits;

    assign cnt_nxt   = cnt + WORDS_LOG2'(1);
    assign sel_tag   = (sel == SEL_D) ? D_Base_Addr[ADDR_W-1:WORDS_LOG2]
                                      : I_Base_Addr[ADDR_W-1:WORDS_LOG2];
    assign bank_addr = {{TAG_W{1'b0}}, cnt};

    rr_arb2 u_arb (
        .clk    (clk),
        .rst    (rst),
        .req_i  (I_change_req),
        .req_d  (D_change_req),
        .load   (state == IDLE),
        .update (state == DONE),
        .gnt    (sel)
    );

`ifdef REFILL_WRITEBACK_EN
    logic [TAG_W-1:0] old_r;
    logic             ext_we_r;

    assign EXT_WE = ext_we_r;
    // The D bank read is registered and its address is held through WB_REQ,
    // so D_Dout is stable for the whole write request.
    assign EXT_Dout = (EXT_Req && ext_we_r) ? D_Dout : '0;
    assign unused_bits = ^{I_Base_Addr[WORDS_LOG2-1:0], D_Base_Addr[WORDS_LOG2-1:0],
                           D_Old_Base[WORDS_LOG2-1:0]};
`else
    assign EXT_WE   = 1'b0;
    assign EXT_Dout = '0;
    assign unused_bits = ^{I_Base_Addr[WORDS_LOG2-1:0], D_Base_Addr[WORDS_LOG2-1:0],
                           D_Old_Base, D_Dirty, D_Dout};
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            cnt      <= '0;
            base_r   <= '0;
            I_Addr   <= '0;
            I_Din    <= '0;
            I_WE     <= 1'b0;
            I_Done   <= 1'b0;
            D_Addr   <= '0;
            D_Din    <= '0;
            D_WE     <= 1'b0;
            D_Done   <= 1'b0;
            EXT_Req  <= 1'b0;
            EXT_Addr <= '0;
`ifdef REFILL_WRITEBACK_EN
            old_r    <= '0;
            ext_we_r <= 1'b0;
`endif
        end else begin
            // Write enables and Done are single-cycle pulses.
            I_WE   <= 1'b0;
            D_WE   <= 1'b0;
            I_Done <= 1'b0;
            D_Done <= 1'b0;
            case (state)
                IDLE: begin
                    if (I_change_req || D_change_req) begin
                        state <= GRANT;
                    end
                end
                GRANT: begin
                    base_r <= sel_tag;
                    cnt    <= '0;
`ifdef REFILL_WRITEBACK_EN
                    if (sel == SEL_D && D_Dirty) begin
                        old_r  <= D_Old_Base[ADDR_W-1:WORDS_LOG2];
                        D_Addr <= '0;
                        state  <= WB_RD;
                    end else
`endif
                    begin
                        EXT_Req  <= 1'b1;
                        EXT_Addr <= {sel_tag, {WORDS_LOG2{1'b0}}};
                        state    <= RD_REQ;
                    end
                end
                RD_REQ: begin
                    if (EXT_Ack) begin
                        EXT_Req <= 1'b0;
                        if (sel == SEL_I) begin
                            I_Addr <= bank_addr;
                            I_Din  <= EXT_Din;
                            I_WE   <= 1'b1;
                        end else begin
                            D_Addr <= bank_addr;
                            D_Din  <= EXT_Din;
                            D_WE   <= 1'b1;
                        end
                        state <= WR_CACHE;
                    end
                end
                WR_CACHE: begin
                    // Terminal test before increment: no wrap, no extra access.
                    if (cnt == CNT_LAST) begin
                        if (sel == SEL_I) begin
                            I_Done <= 1'b1;
                        end else begin
                            D_Done <= 1'b1;
                        end
                        state <= DONE;
                    end else begin
                        cnt      <= cnt_nxt;
                        EXT_Req  <= 1'b1;
                        EXT_Addr <= {base_r, cnt_nxt};
                        state    <= RD_REQ;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
`ifdef REFILL_WRITEBACK_EN
                WB_RD: begin
                    EXT_Req  <= 1'b1;
                    ext_we_r <= 1'b1;
                    EXT_Addr <= {old_r, cnt};
                    state    <= WB_REQ;
                end
                WB_REQ: begin
                    if (EXT_Ack) begin
                        ext_we_r <= 1'b0;
                        if (cnt == CNT_LAST) begin
                            // Writeback finished: go straight into the refill reads.
                            cnt      <= '0;
                            EXT_Addr <= {base_r, {WORDS_LOG2{1'b0}}};
                            state    <= RD_REQ;
                        end else begin
                            cnt     <= cnt_nxt;
                            D_Addr  <= {{TAG_W{1'b0}}, cnt_nxt};
                            EXT_Req <= 1'b0;
                            state   <= WB_RD;
                        end
                    end
                end
`endif
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Self-checking bench for cache_refill_ctrl: transaction-level scoreboard plus latency pins.
// Latency: n/a.
// Backpressure: external memory model inserts fixed or random ack delays and stray acks.
module tb_cache_refill_ctrl;
    import cache_refill_ctrl_pkg::*;

    localparam int N = BLOCK_WORDS;
    localparam logic [31:0] MIX = 32'h5A5A_5A5A;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
    } xact_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        I_change_req = 1'b0;
    logic [31:0] I_Base_Addr = '0;
    logic [31:0] I_Addr, I_Din;
    logic        I_WE, I_Done;
    logic        D_change_req = 1'b0;
    logic [31:0] D_Base_Addr = '0;
    logic [31:0] D_Addr, D_Din;
    logic        D_WE, D_Done;
    logic [31:0] D_Dout = '0;
    logic        D_Dirty = 1'b0;
    logic [31:0] D_Old_Base = '0;
    logic        EXT_Req, EXT_WE;
    logic [31:0] EXT_Addr, EXT_Dout;
    logic [31:0] EXT_Din = '0;
    logic        EXT_Ack = 1'b0;

    always #5 clk = ~clk;

    cache_refill_ctrl dut (
        .clk(clk), .rst(rst),
        .I_change_req(I_change_req), .I_Base_Addr(I_Base_Addr),
        .I_Addr(I_Addr), .I_Din(I_Din), .I_WE(I_WE), .I_Done(I_Done),
        .D_change_req(D_change_req), .D_Base_Addr(D_Base_Addr),
        .D_Addr(D_Addr), .D_Din(D_Din), .D_WE(D_WE), .D_Done(D_Done),
        .D_Dout(D_Dout), .D_Dirty(D_Dirty), .D_Old_Base(D_Old_Base),
        .EXT_Req(EXT_Req), .EXT_WE(EXT_WE), .EXT_Addr(EXT_Addr), .EXT_Dout(EXT_Dout),
        .EXT_Din(EXT_Din), .EXT_Ack(EXT_Ack)
    );

    int checks = 0;
    int errors = 0;

    task automatic eq(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Expected traffic, in order.
    xact_t ext_q[$];
    xact_t iwr_q[$];
    xact_t dwr_q[$];
    int    done_q[$];           // 0 = I, 1 = D; front is the bank being served

    logic [31:0] dbank [N];     // D bank contents for writeback

    int cyc = 0;
    always @(posedge clk) cyc++;

    // D bank port B: registered read.
    always @(posedge clk) D_Dout <= dbank[D_Addr[WORDS_LOG2_DEF-1:0]];

    // External memory: mem[a] = a ^ MIX, ack after cur_dly wait cycles.
    int ack_dly = 0;
    bit rand_dly = 0;
    bit stray_en = 0;
    int wcnt = 0;
    int cur_dly = 0;
    always @(posedge clk) begin
        #1;
        if (EXT_Ack) begin
            EXT_Ack = 1'b0;
            wcnt    = 0;
            cur_dly = rand_dly ? int'($urandom_range(0, 3)) : ack_dly;
        end else if (EXT_Req) begin
            if (wcnt >= cur_dly) begin
                EXT_Ack = 1'b1;
                EXT_Din = EXT_Addr ^ MIX;
            end else begin
                wcnt++;
            end
        end else begin
            wcnt = 0;
            if (stray_en && $urandom_range(0, 3) == 0) begin
                EXT_Ack = 1'b1;
                EXT_Din = $urandom;
            end
        end
    end

    // Observation state.
    int          iw_cnt = 0, i_done_n = 0, d_done_n = 0, ext_wr_n = 0, ext_we_cyc = 0;
    int          i_done_cyc = 0, d_done_cyc = 0;
    logic [31:0] i_first = '0, i_last = '0, ext_first = '0;
    bit          ext_first_pend = 0;
    logic        prev_req = 0, prev_ack = 0, prev_we = 0, prev_iwe = 0, prev_dwe = 0;
    logic [31:0] prev_addr = '0;

    always @(negedge clk) begin : mon
        xact_t x;
        if (!rst) begin
            prev_req = 0; prev_ack = 0; prev_iwe = 0; prev_dwe = 0;
        end else begin
            if (prev_req && !prev_ack) begin
                eq("ext_req_hold", EXT_Req, 1);
                eq("ext_addr_hold", EXT_Addr, prev_addr);
                eq("ext_we_hold", EXT_WE, prev_we);
            end
            if (EXT_WE) ext_we_cyc++;
            if (EXT_Req && EXT_Ack) begin
                eq("ext_expected", ext_q.size() != 0, 1);
                if (ext_q.size() != 0) begin
                    x = ext_q.pop_front();
                    eq("ext_we", EXT_WE, x.we);
                    eq("ext_addr", EXT_Addr, x.addr);
                    if (x.we) eq("ext_dout", EXT_Dout, x.data);
                end
                if (EXT_WE) ext_wr_n++;
                if (ext_first_pend) begin ext_first = EXT_Addr; ext_first_pend = 0; end
            end
            if (I_WE) begin
                eq("i_we_owner", done_q.size() != 0 && done_q[0] == 0, 1);
                eq("i_we_pulse", prev_iwe, 0);
                eq("i_wr_expected", iwr_q.size() != 0, 1);
                if (iwr_q.size() != 0) begin
                    x = iwr_q.pop_front();
                    eq("i_addr", I_Addr, x.addr);
                    eq("i_din", I_Din, x.data);
                end
                if (iw_cnt == 0) i_first = I_Din;
                i_last = I_Din;
                iw_cnt++;
            end
            if (D_WE) begin
                eq("d_we_owner", done_q.size() != 0 && done_q[0] == 1, 1);
                eq("d_we_pulse", prev_dwe, 0);
                eq("d_wr_expected", dwr_q.size() != 0, 1);
                if (dwr_q.size() != 0) begin
                    x = dwr_q.pop_front();
                    eq("d_addr", D_Addr, x.addr);
                    eq("d_din", D_Din, x.data);
                end
            end
            if (I_Done) begin
                eq("i_done_expected", done_q.size() != 0 && done_q[0] == 0 && iwr_q.size() == 0, 1);
                if (done_q.size() != 0 && done_q[0] == 0) void'(done_q.pop_front());
                i_done_n++;
                i_done_cyc = cyc;
            end
            if (D_Done) begin
                eq("d_done_expected", done_q.size() != 0 && done_q[0] == 1 && dwr_q.size() == 0, 1);
                if (done_q.size() != 0 && done_q[0] == 1) void'(done_q.pop_front());
                d_done_n++;
                d_done_cyc = cyc;
            end
            prev_req = EXT_Req; prev_ack = EXT_Ack; prev_we = EXT_WE;
            prev_addr = EXT_Addr; prev_iwe = I_WE; prev_dwe = D_WE;
        end
    end

    // Scoreboard builders: plain address arithmetic over one aligned block.
    task automatic push_refill(input int bank, input logic [31:0] base);
        logic [31:0] b;
        b = base & ~32'(N - 1);
        for (int k = 0; k < N; k++) begin
            ext_q.push_back('{1'b0, b + 32'(k), 32'h0});
            if (bank == 0) iwr_q.push_back('{1'b1, 32'(k), (b + 32'(k)) ^ MIX});
            else           dwr_q.push_back('{1'b1, 32'(k), (b + 32'(k)) ^ MIX});
        end
        done_q.push_back(bank);
    endtask

    task automatic push_wb(input logic [31:0] old_base);
        logic [31:0] b;
        b = old_base & ~32'(N - 1);
        for (int k = 0; k < N; k++) ext_q.push_back('{1'b1, b + 32'(k), dbank[k]});
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        I_change_req = 1'b0;
        D_change_req = 1'b0;
        ext_q.delete(); iwr_q.delete(); dwr_q.delete(); done_q.delete();
        repeat (2) @(negedge clk);
        eq("rst_ext_req", EXT_Req, 0);
        eq("rst_ext_we", EXT_WE, 0);
        eq("rst_ext_addr", EXT_Addr, 0);
        eq("rst_ext_dout", EXT_Dout, 0);
        eq("rst_i_we", I_WE, 0);
        eq("rst_i_addr", I_Addr, 0);
        eq("rst_i_din", I_Din, 0);
        eq("rst_i_done", I_Done, 0);
        eq("rst_d_we", D_WE, 0);
        eq("rst_d_addr", D_Addr, 0);
        eq("rst_d_din", D_Din, 0);
        eq("rst_d_done", D_Done, 0);
        @(negedge clk);
        rst = 1'b1;
    endtask

    // Hold requests until their Done is seen, then confirm all traffic drained.
    task automatic run(input string name, input int budget);
        int n;
        n = 0;
        while ((I_change_req || D_change_req) && n < budget) begin
            @(negedge clk);
            n++;
            if (I_Done) I_change_req = 1'b0;
            if (D_Done) D_change_req = 1'b0;
        end
        eq({name, "_finished"}, I_change_req || D_change_req, 0);
        if (I_change_req || D_change_req) do_reset();
        repeat (3) @(negedge clk);
        eq({name, "_ext_drained"}, ext_q.size(), 0);
        eq({name, "_iwr_drained"}, iwr_q.size(), 0);
        eq({name, "_dwr_drained"}, dwr_q.size(), 0);
        eq({name, "_done_drained"}, done_q.size(), 0);
    endtask

    task automatic set_mem(input int dly, input bit rnd, input bit stray);
        ack_dly = dly; rand_dly = rnd; stray_en = stray; cur_dly = dly;
    endtask

    initial begin
        int c0, saved;
        for (int k = 0; k < N; k++) dbank[k] = $urandom;

        do_reset();

        // Single I refill, zero-wait memory.
        set_mem(0, 0, 0);
        iw_cnt = 0; i_done_n = 0;
        I_Base_Addr = 32'h0000_2400;
        push_refill(0, I_Base_Addr);
        @(negedge clk); I_change_req = 1'b1; c0 = cyc + 1;
        run("t1", 20000);
        eq("t1_latency", i_done_cyc + 1 - c0, 2050);
        eq("t1_i_writes", iw_cnt, 1024);
        eq("t1_first_din", i_first, 32'h5A5A_7E5A);
        eq("t1_last_din", i_last, 32'h5A5A_7DA5);
        eq("t1_done_count", i_done_n, 1);

        // Simultaneous I and D right after reset: I first, then D.
        do_reset();
        I_Base_Addr = $urandom; D_Base_Addr = $urandom; D_Dirty = 1'b0;
        push_refill(0, I_Base_Addr);
        push_refill(1, D_Base_Addr);
        i_done_n = 0; d_done_n = 0;
        @(negedge clk); I_change_req = 1'b1; D_change_req = 1'b1; c0 = cyc + 1;
        run("t2", 20000);
        eq("t2_i_latency", i_done_cyc + 1 - c0, 2050);
        eq("t2_gap", d_done_cyc - i_done_cyc, 2051);
        eq("t2_dones", i_done_n + d_done_n, 2);

        // Ack delayed 3 cycles on every word; low base bits are ignored.
        set_mem(3, 0, 0);
        I_Base_Addr = 32'h0001_3000 | ($urandom & 32'h3FF);
        push_refill(0, I_Base_Addr);
        @(negedge clk); I_change_req = 1'b1; c0 = cyc + 1;
        run("t3", 20000);
        eq("t3_latency", i_done_cyc + 1 - c0, 1024 * 5 + 2);

        // Dirty D block, random latency and stray acks; Dirty changes after grant.
        set_mem(0, 1, 1);
        D_Dirty = 1'b1;
        D_Old_Base = 32'h0000_0400 | ($urandom & 32'h3FF);
        D_Base_Addr = 32'h0000_0800 | ($urandom & 32'h3FF);
        ext_wr_n = 0; ext_we_cyc = 0;
`ifdef REFILL_WRITEBACK_EN
        push_wb(D_Old_Base);
`endif
        push_refill(1, D_Base_Addr);
        @(negedge clk); D_change_req = 1'b1;
        repeat (4) @(negedge clk);
        D_Dirty = 1'b0; D_Old_Base = $urandom;
        run("t5", 40000);
`ifdef REFILL_WRITEBACK_EN
        eq("t5_ext_writes", ext_wr_n, 1024);
`else
        eq("t5_ext_writes", ext_wr_n, 0);
        eq("t5_ext_we_cycles", ext_we_cyc, 0);
`endif

        // Reset during word 500, then restart from cnt = 0.
        set_mem(0, 0, 1);
        I_Base_Addr = $urandom;
        push_refill(0, I_Base_Addr);
        iw_cnt = 0; i_done_n = 0;
        @(negedge clk); I_change_req = 1'b1;
        for (int n = 0; n < 5000 && iw_cnt < 500; n++) @(negedge clk);
        eq("t4_reached_word500", iw_cnt, 500);
        saved = i_done_n;
        do_reset();
        repeat (3) @(negedge clk);
        eq("t4_no_done", i_done_n, saved);
        eq("t4_idle_ext_req", EXT_Req, 0);
        push_refill(0, I_Base_Addr);
        iw_cnt = 0; ext_first_pend = 1;
        @(negedge clk); I_change_req = 1'b1;
        run("t4", 20000);
        eq("t4_restart_addr", ext_first, I_Base_Addr & ~32'h3FF);
        eq("t4_restart_writes", iw_cnt, 1024);

        // last_grant = I: simultaneous D and I -> D first, I on the next IDLE sample.
        set_mem(0, 0, 0);
        I_Base_Addr = $urandom; D_Base_Addr = $urandom;
        push_refill(1, D_Base_Addr);
        push_refill(0, I_Base_Addr);
        @(negedge clk); I_change_req = 1'b1; D_change_req = 1'b1; c0 = cyc + 1;
        run("t6", 20000);
        eq("t6_d_latency", d_done_cyc + 1 - c0, 2050);
        eq("t6_gap", i_done_cyc - d_done_cyc, 2051);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d", checks);
        $fatal(1);
    end

endmodule
